// File: rtl/actel_s2_ureg.sv
// Universal register built from S2-style cells: hold, load, shift, modulo count.
// One mux-plus-flop cell per bit; the gated mode select is formed once and shared by every cell.

module actel_s2_cell #(
    parameter logic RST = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic s1,
    input  logic s0,
    input  logic hold,
    input  logic load,
    input  logic shft,
    input  logic cnt,
    output logic q
);

    typedef enum logic [1:0] {
        M_HOLD  = 2'b00,
        M_LOAD  = 2'b01,
        M_SHIFT = 2'b10,
        M_COUNT = 2'b11
    } mode_t;

    mode_t mode;
    logic  d;

    assign mode = mode_t'({s1, s0});

    // Four-input mux; the cases are exhaustive so no fallback value is ever selected.
    always_comb begin
        d = hold;
        unique case (mode)
            M_HOLD:  d = hold;
            M_LOAD:  d = load;
            M_SHIFT: d = shft;
            M_COUNT: d = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) q <= RST;
        else     q <= d;
    end

endmodule

module actel_s2_ureg #(
    parameter int                 WIDTH      = 8,
    parameter int unsigned        MAX_COUNT  = 2**WIDTH-1,
    parameter bit                 SHIFT_LEFT = 1'b1,
    parameter logic [WIDTH-1:0]   RESET_VAL  = '0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             A0,
    input  logic             B0,
    input  logic             A1,
    input  logic             B1,
    input  logic [WIDTH-1:0] D,
    input  logic             SIN,
    output logic [WIDTH-1:0] Q,
    output logic             SOUT,
    output logic             TC,
    output logic             CO
);

    localparam logic [WIDTH-1:0] MAX_Q = MAX_COUNT[WIDTH-1:0];

    logic             s1;
    logic             s0;
    logic             wrap;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] shift_next;

    assign s1 = A1 | B1;
    assign s0 = A0 & B0;

    // Values above MAX_COUNT (from a load) also wrap, so +1 never passes the limit.
    assign wrap     = (Q >= MAX_Q);
    assign cnt_next = wrap ? '0 : Q + WIDTH'(1);

    generate
        if (SHIFT_LEFT) begin : g_left
            assign shift_next = {Q[WIDTH-2:0], SIN};
            assign SOUT       = Q[WIDTH-1];
        end else begin : g_right
            assign shift_next = {SIN, Q[WIDTH-1:1]};
            assign SOUT       = Q[0];
        end
    endgenerate

    assign TC = (Q == MAX_Q);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            actel_s2_cell #(
                .RST (RESET_VAL[i])
            ) u_cell (
                .clk  (CLK),
                .clr  (CLR),
                .s1   (s1),
                .s0   (s0),
                .hold (Q[i]),
                .load (D[i]),
                .shft (shift_next[i]),
                .cnt  (cnt_next[i]),
                .q    (Q[i])
            );
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (CLR) CO <= 1'b0;
        else     CO <= s1 & s0 & wrap;
    end

endmodule

// File: tb/tb_actel_s2_ureg.sv
// Bench for actel_s2_ureg: two instances (left shift / MAX 9, right shift / MAX 1)
// checked against a behavioural model through an expected-value queue.

module tb_actel_s2_ureg;

    logic       clk = 1'b0;
    logic       clr, a0, b0, a1, b1, sin;
    logic [7:0] d;

    logic [7:0] qa, qb;
    logic       souta, tca, coa;
    logic       soutb, tcb, cob;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        string      tag;
        logic [7:0] qa;
        logic       coa, tca, souta;
        logic [7:0] qb;
        logic       cob, tcb, soutb;
    } exp_t;

    exp_t sb[$];

    logic [7:0] mqa, mqb;
    logic       mcoa, mcob;

    always #5 clk = ~clk;

    actel_s2_ureg #(
        .WIDTH(8), .MAX_COUNT(9), .SHIFT_LEFT(1'b1), .RESET_VAL(8'h5A)
    ) dut_a (
        .CLK(clk), .CLR(clr), .A0(a0), .B0(b0), .A1(a1), .B1(b1),
        .D(d), .SIN(sin), .Q(qa), .SOUT(souta), .TC(tca), .CO(coa)
    );

    actel_s2_ureg #(
        .WIDTH(8), .MAX_COUNT(1), .SHIFT_LEFT(1'b0), .RESET_VAL(8'h00)
    ) dut_b (
        .CLK(clk), .CLR(clr), .A0(a0), .B0(b0), .A1(a1), .B1(b1),
        .D(d), .SIN(sin), .Q(qb), .SOUT(soutb), .TC(tcb), .CO(cob)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Returns {co, q} after one edge.
    function automatic logic [8:0] model(
        input logic [7:0] q, input logic c, input logic x0, input logic y0,
        input logic x1, input logic y1, input logic [7:0] dd, input logic si,
        input int maxc, input bit left, input logic [7:0] rv);
        logic s1, s0;
        s1 = x1 | y1;
        s0 = x0 & y0;
        if (c) return {1'b0, rv};
        if (!s1 && !s0) return {1'b0, q};
        if (!s1 && s0) return {1'b0, dd};
        if (s1 && !s0) begin
            if (left) return {1'b0, q[6:0], si};
            return {1'b0, si, q[7:1]};
        end
        if (int'(q) >= maxc) return {1'b1, 8'h00};
        return {1'b0, q + 8'd1};
    endfunction

    task automatic drive(input string tag, input logic c, input logic x0,
                         input logic y0, input logic x1, input logic y1,
                         input logic [7:0] dd, input logic si);
        exp_t e;
        logic [8:0] r;
        @(posedge clk);
        #2;
        clr = c; a0 = x0; b0 = y0; a1 = x1; b1 = y1; d = dd; sin = si;
        r = model(mqa, c, x0, y0, x1, y1, dd, si, 9, 1'b1, 8'h5A);
        {mcoa, mqa} = r;
        r = model(mqb, c, x0, y0, x1, y1, dd, si, 1, 1'b0, 8'h00);
        {mcob, mqb} = r;
        e.tag   = tag;
        e.qa    = mqa;
        e.coa   = mcoa;
        e.tca   = (mqa == 8'd9);
        e.souta = mqa[7];
        e.qb    = mqb;
        e.cob   = mcob;
        e.tcb   = (mqb == 8'd1);
        e.soutb = mqb[0];
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".qa"},   32'(qa),    32'(e.qa));
            chk({e.tag, ".coa"},  32'(coa),   32'(e.coa));
            chk({e.tag, ".tca"},  32'(tca),   32'(e.tca));
            chk({e.tag, ".souta"},32'(souta), 32'(e.souta));
            chk({e.tag, ".qb"},   32'(qb),    32'(e.qb));
            chk({e.tag, ".cob"},  32'(cob),   32'(e.cob));
            chk({e.tag, ".tcb"},  32'(tcb),   32'(e.tcb));
            chk({e.tag, ".soutb"},32'(soutb), 32'(e.soutb));
        end
    end

    initial begin
        clr = 1'b0; a0 = 1'b0; b0 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        d = 8'h00; sin = 1'b0;
        mqa = 8'h00; mqb = 8'h00; mcoa = 1'b0; mcob = 1'b0;

        // Reset with count selects asserted.
        drive("rst", 1, 1, 1, 1, 1, 8'h00, 0);

        drive("load_c3", 0, 1, 1, 0, 0, 8'hC3, 0);
        for (int i = 0; i < 5; i++)
            drive("hold", 0, 1, 0, 0, 0, 8'h3C, 1);

        drive("load_81", 0, 1, 1, 0, 0, 8'h81, 0);
        drive("shift0", 0, 0, 0, 0, 1, 8'h00, 0);
        for (int i = 0; i < 8; i++)
            drive("shift1", 0, 0, 0, 0, 1, 8'h00, 1);

        drive("load_7", 0, 1, 1, 0, 0, 8'h07, 0);
        for (int i = 0; i < 4; i++)
            drive("count", 0, 1, 1, 1, 0, 8'h00, 0);

        drive("load_f0", 0, 1, 1, 0, 0, 8'hF0, 0);
        drive("oor_cnt", 0, 1, 1, 0, 1, 8'h00, 0);
        drive("post_wrap_hold", 0, 0, 0, 0, 0, 8'h00, 0);

        drive("load_4", 0, 1, 1, 0, 0, 8'h04, 0);
        drive("cnt_to5", 0, 1, 1, 1, 1, 8'h00, 0);
        drive("clr_mid", 1, 1, 1, 1, 1, 8'h00, 0);
        drive("resume", 0, 1, 1, 1, 1, 8'h00, 0);
        drive("resume2", 0, 1, 1, 1, 1, 8'h00, 0);

        for (int i = 0; i < 60; i++)
            drive("rand", ($urandom_range(0, 15) == 0), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  8'($urandom_range(0, 255)), 1'($urandom));

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #3;
        if (sb.size() != 0) chk("drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
